// File: rtl/jtag_mem_arb_pkg.sv
// Shared definitions for the JTAG/core memory arbiter: FSM states, requester select, op encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jtag_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    SEL_CORE = 1'b0,
    SEL_DBG  = 1'b1
  } sel_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  function automatic logic is_write(input logic we);
    return we == OP_WRITE;
  endfunction

endpackage

// File: rtl/jtag_mem_arb_req_buf.sv
// One-entry pending buffer for debug requests with sticky overflow.
// Latency: an incoming push is visible on the head outputs in the same cycle (bypass when empty).
// Backpressure: none; a push into a full entry that is not popped that cycle is dropped and flagged.
// Ports: push_* incoming request, pop_i consume head, valid_o head present, full_o stored entry,
//        ovf_o sticky drop flag, head_* request at the head.
module jtag_req_buf
  import jtag_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              push_we_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_wdata_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic              full_o,
  output logic              ovf_o,
  output logic              head_we_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_wdata_o
);

  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic              load;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // When empty, a push that is popped in the same cycle passes straight through
  // and is never stored; when full, a push is only stored if the old entry leaves.
  assign load   = push_i & (full_q ? pop_i : ~pop_i);
  assign full_d = full_q ? (~pop_i | push_i) : (push_i & ~pop_i);
  assign ovf_d  = ovf_q | (push_i & full_q & ~pop_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      we_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      full_q <= full_d;
      ovf_q  <= ovf_d;
      if (load) begin
        we_q    <= push_we_i;
        addr_q  <= push_addr_i;
        wdata_q <= push_wdata_i;
      end
    end
  end

  assign valid_o      = full_q | push_i;
  assign full_o       = full_q;
  assign ovf_o        = ovf_q;
  assign head_we_o    = full_q ? we_q    : push_we_i;
  assign head_addr_o  = full_q ? addr_q  : push_addr_i;
  assign head_wdata_o = full_q ? wdata_q : push_wdata_i;

endmodule

// File: rtl/jtag_mem_arb.sv
// Arbitrates a single memory port between a core and a JTAG debug requester, debug first with starvation guard.
// Latency: grant to mem_req_o 1 cycle, grant to read rvalid 2 cycles; one access in flight at a time.
// Backpressure: core holds core_req_i until core_gnt_o; debug pulses are buffered (one entry), excess dropped with sticky dbg_ovf_o.
// Ports: core_* core request/grant/read return, dbg_* debug pulse/read return/overflow,
//        mem_* memory strobe and read data, hold_o core stall while debug is pending or in flight.
module jtag_mem_arb
  import jtag_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_rvalid_o,
  output logic              dbg_ovf_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              hold_o
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  state_e            state_q, state_d;
  sel_e              sel_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic              dbg_valid, dbg_full, dbg_head_we;
  logic [ADDR_W-1:0] dbg_head_addr;
  logic [DATA_W-1:0] dbg_head_wdata;
  logic              starving, pick_dbg, pick_core;
  logic              resp_core, resp_dbg;

  jtag_req_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_req_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (dbg_req_i),
    .push_we_i    (dbg_we_i),
    .push_addr_i  (dbg_addr_i),
    .push_wdata_i (dbg_wdata_i),
    .pop_i        (pick_dbg),
    .valid_o      (dbg_valid),
    .full_o       (dbg_full),
    .ovf_o        (dbg_ovf_o),
    .head_we_o    (dbg_head_we),
    .head_addr_o  (dbg_head_addr),
    .head_wdata_o (dbg_head_wdata)
  );

  // Starvation only matters while the core is actually waiting.
  assign starving  = core_req_i & (starve_q == CNT_W'(STARVE_MAX));
  assign pick_dbg  = (state_q == IDLE) & dbg_valid & ~starving;
  assign pick_core = (state_q == IDLE) & ~pick_dbg & core_req_i;
  assign resp_core = (state_q == RESP) & (sel_q == SEL_CORE);
  assign resp_dbg  = (state_q == RESP) & (sel_q == SEL_DBG);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_dbg || pick_core) state_d = ISSUE;
      ISSUE:   state_d = is_write(we_q) ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    core_gnt_o    = pick_core;
    mem_req_o     = (state_q == ISSUE);
    mem_we_o      = (state_q == ISSUE) & is_write(we_q);
    core_rvalid_o = resp_core;
    dbg_rvalid_o  = resp_dbg;
    core_rdata_o  = resp_core ? mem_rdata_i : '0;
    dbg_rdata_o   = resp_dbg  ? mem_rdata_i : '0;
    // An arriving pulse already counts as pending so the core stalls in that same cycle.
    hold_o        = dbg_valid | dbg_full | ((state_q != IDLE) & (sel_q == SEL_DBG));
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  always_comb begin
    starve_d = starve_q;
    if (!core_req_i || pick_core)
      starve_d = '0;
    else if (pick_dbg && (starve_q != CNT_W'(STARVE_MAX)))
      starve_d = starve_q + CNT_W'(1);
  end

  // Access latch: captured at selection, held until the next selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= SEL_CORE;
      we_q     <= OP_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
      if (pick_dbg) begin
        sel_q   <= SEL_DBG;
        we_q    <= dbg_head_we;
        addr_q  <= dbg_head_addr;
        wdata_q <= dbg_head_wdata;
      end else if (pick_core) begin
        sel_q   <= SEL_CORE;
        we_q    <= core_we_i;
        addr_q  <= core_addr_i;
        wdata_q <= core_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_jtag_mem_arb.sv
module tb_jtag_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        core_req_i = 1'b0, core_we_i = 1'b0;
  logic [31:0] core_addr_i = '0, core_wdata_i = '0;
  logic        core_gnt_o, core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        dbg_req_i = 1'b0, dbg_we_i = 1'b0;
  logic [31:0] dbg_addr_i = '0, dbg_wdata_i = '0;
  logic        dbg_rvalid_o, dbg_ovf_o;
  logic [31:0] dbg_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        hold_o;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jtag_mem_arb #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_rvalid_o(dbg_rvalid_o), .dbg_ovf_o(dbg_ovf_o), .dbg_rdata_o(dbg_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .hold_o(hold_o)
  );

  task automatic clr_in();
    core_req_i = 1'b0; core_we_i = 1'b0; core_addr_i = '0; core_wdata_i = '0;
    dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
  endtask

  task automatic test_reset();
    logic [31:0] any_out;
    @(negedge clk);
    clr_in();
    rst_n = 1'b0;
    #1;
    any_out = {core_gnt_o, core_rvalid_o, dbg_rvalid_o, dbg_ovf_o, mem_req_o, mem_we_o, hold_o};
    checks++; if (any_out !== 32'h0) begin errs++; $display("FAIL reset_flags: got %h want 0", any_out); end
    checks++; if (dbg_ovf_o !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b want 0", dbg_ovf_o); end
    checks++; if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
      errs++; $display("FAIL reset_mem_bus: got addr %h wdata %h want 0", mem_addr_o, mem_wdata_o); end
    checks++; if (core_rdata_o !== 32'h0 || dbg_rdata_o !== 32'h0) begin
      errs++; $display("FAIL reset_rdata: got core %h dbg %h want 0", core_rdata_o, dbg_rdata_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (mem_req_o !== 1'b0 || hold_o !== 1'b0) begin
      errs++; $display("FAIL reset_release: got mem_req %b hold %b want 0 0", mem_req_o, hold_o); end
  endtask

  task automatic test_dbg_write();
    @(negedge clk);
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h100; dbg_wdata_i = 32'hDEADBEEF;
    #1;
    checks++; if (hold_o !== 1'b1) begin errs++; $display("FAIL dbgwr_hold_c0: got %b want 1", hold_o); end
    checks++; if (mem_req_o !== 1'b0) begin errs++; $display("FAIL dbgwr_req_c0: got %b want 0", mem_req_o); end
    @(negedge clk);
    clr_in(); #1;
    checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1) begin
      errs++; $display("FAIL dbgwr_strobe: got req %b we %b want 1 1", mem_req_o, mem_we_o); end
    checks++; if (mem_addr_o !== 32'h100 || mem_wdata_o !== 32'hDEADBEEF) begin
      errs++; $display("FAIL dbgwr_bus: got %h/%h want 00000100/deadbeef", mem_addr_o, mem_wdata_o); end
    checks++; if (hold_o !== 1'b1) begin errs++; $display("FAIL dbgwr_hold_c1: got %b want 1", hold_o); end
    @(negedge clk); #1;
    checks++; if (mem_req_o !== 1'b0 || hold_o !== 1'b0) begin
      errs++; $display("FAIL dbgwr_end: got req %b hold %b want 0 0", mem_req_o, hold_o); end
    checks++; if (mem_addr_o !== 32'h100) begin errs++; $display("FAIL dbgwr_addr_hold: got %h want 00000100", mem_addr_o); end
  endtask

  task automatic test_core_read();
    mem_rdata_i = 32'h12345678;
    @(negedge clk);
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h40;
    #1;
    checks++; if (core_gnt_o !== 1'b1) begin errs++; $display("FAIL crd_gnt: got %b want 1", core_gnt_o); end
    checks++; if (hold_o !== 1'b0) begin errs++; $display("FAIL crd_hold: got %b want 0", hold_o); end
    @(negedge clk);
    clr_in(); #1;
    checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h40) begin
      errs++; $display("FAIL crd_issue: got req %b we %b addr %h want 1 0 00000040", mem_req_o, mem_we_o, mem_addr_o); end
    checks++; if (core_rvalid_o !== 1'b0) begin errs++; $display("FAIL crd_early_rvalid: got %b want 0", core_rvalid_o); end
    @(negedge clk); #1;
    checks++; if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'h12345678) begin
      errs++; $display("FAIL crd_rvalid: got %b %h want 1 12345678", core_rvalid_o, core_rdata_o); end
    checks++; if (dbg_rvalid_o !== 1'b0) begin errs++; $display("FAIL crd_dbg_rvalid: got %b want 0", dbg_rvalid_o); end
    @(negedge clk); #1;
    checks++; if (core_rvalid_o !== 1'b0) begin errs++; $display("FAIL crd_rvalid_pulse: got %b want 0", core_rvalid_o); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    core_req_i = 1'b1; core_we_i = 1'b1; core_addr_i = 32'h50; core_wdata_i = 32'hC0C0;
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h180; dbg_wdata_i = 32'hD0D0;
    #1;
    checks++; if (core_gnt_o !== 1'b0) begin errs++; $display("FAIL sim_core_gnt_c0: got %b want 0", core_gnt_o); end
    @(negedge clk);
    dbg_req_i = 1'b0; #1;
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h180 || mem_wdata_o !== 32'hD0D0) begin
      errs++; $display("FAIL sim_dbg_first: got req %b addr %h wdata %h want 1 00000180 0000d0d0", mem_req_o, mem_addr_o, mem_wdata_o); end
    @(negedge clk); #1;
    checks++; if (core_gnt_o !== 1'b1) begin errs++; $display("FAIL sim_core_gnt_c2: got %b want 1", core_gnt_o); end
    @(negedge clk);
    clr_in(); #1;
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h50 || mem_wdata_o !== 32'hC0C0) begin
      errs++; $display("FAIL sim_core_issue: got req %b addr %h wdata %h want 1 00000050 0000c0c0", mem_req_o, mem_addr_o, mem_wdata_o); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    mem_rdata_i = 32'h0BADF00D;
    @(negedge clk);
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h44;
    #1;
    checks++; if (core_gnt_o !== 1'b1) begin errs++; $display("FAIL ovf_core_gnt: got %b want 1", core_gnt_o); end
    @(negedge clk);
    clr_in();
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h300; dbg_wdata_i = 32'h11111111;
    #1;
    checks++; if (hold_o !== 1'b1 || dbg_ovf_o !== 1'b0) begin
      errs++; $display("FAIL ovf_first_pulse: got hold %b ovf %b want 1 0", hold_o, dbg_ovf_o); end
    @(negedge clk);
    dbg_addr_i = 32'h304; dbg_wdata_i = 32'h22222222;
    #1;
    checks++; if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'h0BADF00D) begin
      errs++; $display("FAIL ovf_core_rvalid: got %b %h want 1 0badf00d", core_rvalid_o, core_rdata_o); end
    @(negedge clk);
    clr_in(); #1;
    checks++; if (dbg_ovf_o !== 1'b1) begin errs++; $display("FAIL ovf_flag_set: got %b want 1", dbg_ovf_o); end
    @(negedge clk); #1;
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300 || mem_wdata_o !== 32'h11111111) begin
      errs++; $display("FAIL ovf_kept_first: got req %b addr %h wdata %h want 1 00000300 11111111", mem_req_o, mem_addr_o, mem_wdata_o); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (dbg_ovf_o !== 1'b1 || mem_req_o !== 1'b0 || hold_o !== 1'b0) begin
      errs++; $display("FAIL ovf_sticky: got ovf %b req %b hold %b want 1 0 0", dbg_ovf_o, mem_req_o, hold_o); end
  endtask

  // Debug reads every 3 cycles keep a debug request waiting at every arbitration,
  // core writes continuously: expect D0..D3, C, D4..D7, C, D8 on the memory port.
  task automatic test_starvation();
    logic [31:0] seq[$];
    logic [31:0] exp_seq[11];
    int rv;
    exp_seq = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h40, 32'h210,
                32'h214, 32'h218, 32'h21C, 32'h40, 32'h220};
    rv = 0;
    for (int t = 0; t < 36; t++) begin
      @(negedge clk);
      core_req_i = 1'b1; core_we_i = 1'b1; core_addr_i = 32'h40; core_wdata_i = 32'hC0DE;
      dbg_req_i = ((t % 3) == 0) && (t <= 24);
      dbg_we_i = 1'b0; dbg_addr_i = 32'h200 + 32'(t / 3) * 4;
      #1;
      if (mem_req_o === 1'b1) seq.push_back(mem_addr_o);
      if (dbg_rvalid_o === 1'b1) rv++;
    end
    @(negedge clk);
    clr_in();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (i >= seq.size()) begin
        errs++; $display("FAIL starve_seq[%0d]: got no access want %h", i, exp_seq[i]);
      end else if (seq[i] !== exp_seq[i]) begin
        errs++; $display("FAIL starve_seq[%0d]: got %h want %h", i, seq[i], exp_seq[i]);
      end
    end
    checks++; if (rv !== 9) begin errs++; $display("FAIL starve_dbg_rvalids: got %0d want 9", rv); end
    checks++; if (dbg_ovf_o !== 1'b0) begin errs++; $display("FAIL starve_no_loss: got ovf %b want 0", dbg_ovf_o); end
  endtask

  task automatic test_reset_mid_resp();
    int late;
    late = 0;
    mem_rdata_i = 32'hABCD0123;
    @(negedge clk);
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h3F0;
    @(negedge clk);
    clr_in();
    @(negedge clk); #1;
    checks++; if (dbg_rvalid_o !== 1'b1 || dbg_rdata_o !== 32'hABCD0123) begin
      errs++; $display("FAIL rst_resp_pre: got %b %h want 1 abcd0123", dbg_rvalid_o, dbg_rdata_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (dbg_rvalid_o !== 1'b0 || dbg_rdata_o !== 32'h0 || hold_o !== 1'b0) begin
      errs++; $display("FAIL rst_resp_async: got rvalid %b rdata %h hold %b want 0 0 0", dbg_rvalid_o, dbg_rdata_o, hold_o); end
    checks++; if (mem_addr_o !== 32'h0 || mem_req_o !== 1'b0) begin
      errs++; $display("FAIL rst_resp_mem: got addr %h req %b want 0 0", mem_addr_o, mem_req_o); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (dbg_rvalid_o !== 1'b0 || mem_req_o !== 1'b0) late++;
    end
    checks++; if (late !== 0) begin errs++; $display("FAIL rst_resp_after: got %0d stray cycles want 0", late); end
  endtask

  initial begin
    test_reset();
    test_dbg_write();
    test_core_read();
    test_simultaneous();
    test_overflow();
    test_reset();
    test_starvation();
    test_reset_mid_resp();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end

endmodule

// File: doc/jtag_mem_arb.md
JTAG_MEM_ARB -- requirements
Module: jtag_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, maximum consecutive debug grants while core waits.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports core_req_i/core_we_i  input  1 each  core access request, held until granted; write enable.
REQ-007 SHALL have ports core_addr_i/core_wdata_i  input  ADDR_W/DATA_W  core address and write data.
REQ-008 SHALL have ports core_gnt_o/core_rvalid_o  output  1 each  grant pulse; read-data-valid pulse.
REQ-009 SHALL have port core_rdata_o  output  DATA_W  core read data, meaningful when core_rvalid_o=1.
REQ-010 SHALL have ports dbg_req_i/dbg_we_i  input  1 each  single-cycle debug request pulse; write enable.
REQ-011 SHALL have ports dbg_addr_i/dbg_wdata_i  input  ADDR_W/DATA_W  debug address and data, sampled with dbg_req_i.
REQ-012 SHALL have ports dbg_rvalid_o/dbg_ovf_o  output  1 each  debug read-valid pulse; sticky overflow flag.
REQ-013 SHALL have port dbg_rdata_o  output  DATA_W  debug read data.
REQ-014 SHALL have ports mem_req_o/mem_we_o  output  1 each  memory access strobe; write enable.
REQ-015 SHALL have ports mem_addr_o/mem_wdata_o  output  ADDR_W/DATA_W  memory address, write data.
REQ-016 SHALL have port mem_rdata_i  input  DATA_W  memory read data, valid the cycle after a read strobe.
REQ-017 SHALL have port hold_o  output  1  core pipeline stall while debug traffic is pending or in flight.

Function
REQ-018 SHALL capture every dbg_req_i pulse (we, addr, wdata) into a one-entry pending buffer.
REQ-019 SHALL, on dbg_req_i while the buffer is full and not freed that cycle, drop the request and set dbg_ovf_o (cleared only by reset).
REQ-020 SHALL accept dbg_req_i in the cycle the buffer is freed (simultaneous free and fill is not overflow).
REQ-021 SHALL use FSM states IDLE, ISSUE, RESP; reset state IDLE.
REQ-022 IDLE: if debug pending and not starving, select debug, free buffer, go ISSUE; else if core_req_i, select core, pulse core_gnt_o, go ISSUE; else stay.
REQ-023 Starvation: count consecutive debug selections while core_req_i=1; when count equals STARVE_MAX, core SHALL win next arbitration; count clears on any core grant or when core_req_i=0.
REQ-024 ISSUE: drive mem_req_o=1 for exactly one cycle with latched we/addr/wdata; write returns to IDLE, read goes RESP.
REQ-025 RESP: forward mem_rdata_i to selected requester's rdata and pulse its rvalid for one cycle; return to IDLE.
REQ-026 Latency from accepted request to mem_req_o: 1 cycle; read rvalid: 2 cycles after acceptance.
REQ-027 mem_req_o, mem_we_o SHALL be 0 outside ISSUE; mem_addr_o/mem_wdata_o hold last latched values.
REQ-028 hold_o SHALL be 1 whenever the debug buffer is full or the in-flight access is a debug access; else 0.
REQ-029 Core requests SHALL never be dropped; core holds core_req_i until core_gnt_o.

Reset
REQ-030 On rst_n low, asynchronously: state IDLE, buffer empty, starvation count 0, all outputs 0 (including dbg_ovf_o, rdata outputs, mem_addr_o, mem_wdata_o).
REQ-031 Reset mid-access SHALL abort it with no rvalid pulse after release.

Structure
REQ-032 FSM state encodings and op constants SHALL live in the shared jtag defines file.
REQ-033 The debug pending buffer SHALL be sub-module jtag_req_buf (one entry, push/pop, full, overflow).

Verification
REQ-034 Debug write pulse addr=0x100 data=0xDEADBEEF, core idle -> mem_req_o=1, mem_we_o=1, addr 0x100 exactly one cycle later; hold_o=1 for 2 cycles.
REQ-035 Core read addr=0x40, mem returns 0x12345678 -> core_gnt_o same cycle, mem_req_o next, core_rvalid_o with 0x12345678 the cycle after.
REQ-036 Core requesting continuously, debug pulse every 3 cycles, STARVE_MAX=4 -> core granted after every 4th debug grant, no debug loss.
REQ-037 Two debug pulses in consecutive cycles while core read in flight -> second dropped, dbg_ovf_o=1 until reset.
REQ-038 Simultaneous core_req_i and dbg_req_i from IDLE -> debug issued first, core granted next IDLE.
REQ-039 rst_n asserted during RESP of a debug read -> all outputs 0 immediately, no dbg_rvalid_o after release.
